// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with private HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic [31:0] hilo,
  output logic        busy,
  output logic        md_stall
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] prod_s, prod_u, res;
  logic [31:0] bs, quo_s, rem_s, quo_u, rem_u;
  logic        md_op, dz, done;
  assign md_op    = op >= 3'd1 && op <= 3'd4;
  assign busy     = state_q == RUN;
  assign md_stall = busy | (start & md_op);
  assign hilo     = rd_sel ? hi_q : lo_q;
  // Arithmetic on latched operands; a divisor of 1 is substituted for /0 and
  // for 0x80000000/-1 so the divider never overflows (the latter then yields
  // quotient 0x80000000, remainder 0 by construction).
  always_comb begin
    dz     = b_q == 32'd0;
    bs     = (dz || (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)) ? 32'd1 : b_q;
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    quo_s  = $signed(a_q) / $signed(bs);
    rem_s  = $signed(a_q) % $signed(bs);
    quo_u  = a_q / bs;
    rem_u  = a_q % bs;
    res    = op_q == 3'd1 ? prod_s : op_q == 3'd2 ? prod_u :
             op_q == 3'd3 ? {rem_s, quo_s} : {rem_u, quo_u};
    done   = state_q == RUN && cnt_q == CW'(1);
  end
  // Next-state: issue/mthi/mtlo from IDLE, countdown and writeback in RUN
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && start) begin
      if (md_op) begin
        a_d     = a;
        b_d     = b;
        op_d    = op;
        cnt_d   = op <= 3'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        state_d = RUN;
      end
      hi_d = op == 3'd5 ? a : hi_q;
      lo_d = op == 3'd6 ? a : lo_q;
    end
    if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (done) begin
        state_d = IDLE;
        if (!(dz && op_q >= 3'd3)) {hi_d, lo_d} = res;
      end
    end
  end
  // State registers with synchronous reset discarding any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
  logic        clk = 0, reset, start, rd_sel;
  logic [2:0]  op;
  logic [31:0] a, b, hilo;
  logic        busy, md_stall;
  int          n_run = 0, n_fail = 0;
  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_sel(rd_sel), .hilo(hilo), .busy(busy), .md_stall(md_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    rd_sel = 0;
    #1 chk({tag, "_lo"}, hilo, elo);
    rd_sel = 1;
    #1 chk({tag, "_hi"}, hilo, ehi);
  endtask
  task automatic wait_idle(input string tag, input int n);
    int cnt = 0;
    int st = 0;
    while (busy && cnt < 100) begin
      cnt++;
      st += md_stall;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, cnt, n);
    chk({tag, "_stall_len"}, st, n);
  endtask
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo);
    start = 1; op = o; a = x; b = y;
    #1 chk({tag, "_stall_issue"}, md_stall, 1);
    @(negedge clk);
    start = 0; op = 0;
    wait_idle(tag, n);
    rd_hilo(tag, ehi, elo);
  endtask
  initial begin
    reset = 1; start = 0; op = 0; a = 0; b = 0; rd_sel = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stall", md_stall, 0);
    rd_hilo("rst", 0, 0);
    reset = 0;
    @(negedge clk);
    run_op("mult", 1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div", 3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divneg", 3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("divovf", 3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("divu", 4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    @(negedge clk);
    start = 1; op = 5; a = 32'h1234_5678;
    #1 chk("mthi_stall", md_stall, 0);
    @(negedge clk);
    op = 6; a = 32'h9ABC_DEF0;
    #1 chk("mtlo_stall", md_stall, 0);
    chk("mthi_busy", busy, 0);
    @(negedge clk);
    start = 0; op = 7; a = 0;
    #1 chk("rsvd_stall", md_stall, 0);
    rd_hilo("mthilo", 32'h1234_5678, 32'h9ABC_DEF0);
    op = 0;
    @(negedge clk);
    start = 1; op = 1; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 0; op = 0;
    @(negedge clk);
    start = 1; op = 6; a = 32'hDEAD_BEEF;
    #1 chk("ign_stall", md_stall, 1);
    @(negedge clk);
    start = 0; op = 0; a = 0;
    rd_hilo("inflight_old", 32'h1234_5678, 32'h9ABC_DEF0);
    wait_idle("ign", 3);
    rd_hilo("ign", 32'd0, 32'd42);
    @(negedge clk);
    start = 1; op = 3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 0; op = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", busy, 0);
    rd_hilo("abort", 0, 0);
    repeat (12) @(negedge clk);
    chk("abort_busy_late", busy, 0);
    rd_hilo("abort_late", 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit with private HI/LO registers for the pipelined MIPS core. It accepts mult, multu, div, divu, mthi and mtlo from the E stage and models multi-cycle latency with a busy counter. It returns HI or LO for mfhi/mflo on `hilo`, which the E/M pipeline register captures alongside the ALU result. It also raises a stall request so the hazard unit freezes F/D while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (must be ≥1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  E-stage instruction in `op` is valid this cycle.
- `op`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `rd_sel`  in  1  0 selects LO, 1 selects HI onto `hilo`.
- `hilo`  out  32  combinational: `rd_sel ? HI : LO`.
- `busy`  out  1  registered; high while a mult/div is in flight.
- `md_stall`  out  1  combinational: `busy | (start & op∈{1,2,3,4})`.

## Operation
- State: HI, LO (32 each); `cnt` (counter, wide enough for max(MULT_CYCLES, DIV_CYCLES)); latched `op_q`, `a_q`, `b_q`; `busy`.
- Two states:
  - IDLE (busy=0).
  - RUN (busy=1).
- IDLE, `start` with op 1–4:
  - Latch `a`, `b`, `op`.
  - Load `cnt` = N, where N is MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, `start` with op 5: HI ← `a`, stay IDLE.
- IDLE, `start` with op 6: LO ← `a`, stay IDLE.
- RUN:
  - Each cycle, `cnt` decrements.
  - On the edge where `cnt` == 1: write the result to HI/LO and go to IDLE. busy falls on that same edge.
- Results:
  - mult: {HI,LO} = signed(a_q)×signed(b_q), 64-bit.
  - multu: {HI,LO} = unsigned product.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
- Boundary rules:
  - Division by zero (`b_q`==0): HI and LO unchanged, full DIV_CYCLES busy time still spent.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - `start` while busy (any op, including mthi/mtlo): ignored. No state changes and the in-flight op is unaffected. The hazard unit must never allow this, and the bench checks that it is ignored.
  - `rd_sel` read while busy returns the old HI/LO. Correctness relies on the external stall of mfhi/mflo on `md_stall`.
  - Reset, including mid-operation: HI=0, LO=0, busy=0, cnt=0, latched operands 0. Any pending result is discarded.

## Timing
- Reset values: `busy`=0 and `hilo`=0. `md_stall` is 0 unless `start` is asserted with op 1–4 in the reset cycle, in which case it follows its combinational equation.
- mult/div with `start` sampled at edge T0:
  - `busy`=1 during cycles T0..T0+N−1.
  - HI/LO are updated and `busy`=0 at edge T0+N.
  - mfhi/mflo first observes the new value in the cycle after edge T0+N.
- `md_stall` is high in the issue cycle (combinationally) and through the N busy cycles, N+1 cycles total.
- mthi/mtlo take effect at the next edge. `hilo` reflects the new value in the following cycle with zero stall.
- `start` in the cycle immediately after busy falls is accepted normally (back-to-back issue).

## Test plan
- Reset, then mult a=0xFFFFFFFE (−2), b=3 with rd_sel=0 → busy high exactly 5 cycles; afterwards LO=0xFFFFFFFA and HI=0xFFFFFFFF.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles; afterwards LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Follow with divu a=7, b=0 → HI/LO unchanged after 10 busy cycles.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles → rd_sel=1 gives 0x12345678 and rd_sel=0 gives 0x9ABCDEF0, with md_stall never asserted.
- mult in progress, mtlo a=0xDEADBEEF issued at busy cycle 2 → ignored; LO equals the mult result at completion.
- div started, reset asserted at busy cycle 4 → next cycle busy=0 and HI=LO=0; no later write from the aborted div.
